adder_seq_ctrl: RTL and testbench

Sequencer that runs multi-byte add/subtract on the project's shared 8-bit combinational adder. Operand bytes arrive one per handshake from the pin-side input logic. The block drives the adder byte by byte and chains carry through its own register. Sum bytes, then a final carry byte, stream out through a valid/ready port toward uo_out.

---
 rtl/adder_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Byte-serial add/subtract sequencer driving a shared 8-bit combinational adder.
// Operands arrive interleaved LSB first; sum bytes and a final carry byte stream out.
module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sub,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_cin,
    input  logic [7:0] add_sum,
    input  logic       add_cout,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);

    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_A,
        S_GET_B,
        S_ADD,
        S_EMIT,
        S_CARRY
    } state_t;

    state_t           state_reg, state_next;
    logic             sub_reg, sub_next;
    logic             carry_reg, carry_next;
    logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
    logic [7:0]       a_reg, a_next;
    logic [7:0]       add_a_reg, add_a_next;
    logic [7:0]       add_b_reg, add_b_next;
    logic             add_cin_reg, add_cin_next;
    logic [7:0]       out_data_reg, out_data_next;
    logic             done_reg, done_next;

    // B operand is conditionally inverted as it is accepted, so the adder
    // only ever sees A + B' + cin.
    logic [7:0] b_cond;
    for (genvar gi = 0; gi < 8; gi++) begin : g_b_cond
        assign b_cond[gi] = in_data[gi] ^ sub_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            sub_reg      <= 1'b0;
            carry_reg    <= 1'b0;
            byte_cnt_reg <= '0;
            a_reg        <= 8'h00;
            add_a_reg    <= 8'h00;
            add_b_reg    <= 8'h00;
            add_cin_reg  <= 1'b0;
            out_data_reg <= 8'h00;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sub_reg      <= sub_next;
            carry_reg    <= carry_next;
            byte_cnt_reg <= byte_cnt_next;
            a_reg        <= a_next;
            add_a_reg    <= add_a_next;
            add_b_reg    <= add_b_next;
            add_cin_reg  <= add_cin_next;
            out_data_reg <= out_data_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        sub_next      = sub_reg;
        carry_next    = carry_reg;
        byte_cnt_next = byte_cnt_reg;
        a_next        = a_reg;
        add_a_next    = add_a_reg;
        add_b_next    = add_b_reg;
        add_cin_next  = add_cin_reg;
        out_data_next = out_data_reg;
        done_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    sub_next      = sub;
                    carry_next    = sub;
                    byte_cnt_next = '0;
                    state_next    = S_GET_A;
                end
            end
            S_GET_A: begin
                if (in_valid) begin
                    a_next     = in_data;
                    state_next = S_GET_B;
                end
            end
            S_GET_B: begin
                // Adder operands are loaded here so they are stable for the
                // whole ADD cycle and simply hold afterwards.
                if (in_valid) begin
                    add_a_next   = a_reg;
                    add_b_next   = b_cond;
                    add_cin_next = carry_reg;
                    state_next   = S_ADD;
                end
            end
            S_ADD: begin
                out_data_next = add_sum;
                carry_next    = add_cout;
                state_next    = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (byte_cnt_reg == LAST_IDX) begin
                        out_data_next = {7'b0, carry_reg};
                        state_next    = S_CARRY;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + CNT_W'(1);
                        state_next    = S_GET_A;
                    end
                end
            end
            S_CARRY: begin
                if (out_ready) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == S_GET_A) || (state_reg == S_GET_B);
    assign out_valid = (state_reg == S_EMIT) || (state_reg == S_CARRY);
    assign out_last  = (state_reg == S_CARRY);
    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign out_data  = out_data_reg;
    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign add_cin   = add_cin_reg;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Bench for adder_seq_ctrl: directed and random operations checked against
// whole-word arithmetic, with a behavioural 8-bit adder attached.
module tb_adder_seq_ctrl;

    localparam int N = 4;
    localparam int W = 8 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic [7:0] add_sum;
    logic       add_cout;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    logic [8:0] add_full;
    assign add_full = 9'(add_a) + 9'(add_b) + 9'(add_cin);
    assign add_sum  = add_full[7:0];
    assign add_cout = add_full[8];

    adder_seq_ctrl #(.NBYTES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ctl"}, 32'({in_ready, out_valid, out_last, busy, done, add_cin}), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data), 32'd0);
        chk({tag, "_add_ab"}, 32'({add_a, add_b}), 32'd0);
    endtask

    // Offer one operand byte until accepted; junk data when in_valid is low.
    task automatic feed_byte(input logic [7:0] d, input bit rnd, input bit start_pulse);
        int  t;
        bit  hs;
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 100) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = in_valid ? d : 8'($urandom);
            start    = start_pulse && (t == 0);
            sub      = 1'($urandom);
            hs       = in_valid && in_ready;
            @(negedge clk);
            t++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("in_handshake", 32'(hs), 32'd1);
    endtask

    // Expect one result byte, stall it, then accept it.
    task automatic take_out(input logic [7:0] exp, input bit last, input int stall, input bit start_pulse);
        logic [7:0] held;
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_data", 32'(out_data), 32'(exp));
        chk("out_last", 32'(out_last), 32'(last));
        chk("in_ready_in_emit", 32'(in_ready), 32'd0);
        held = out_data;
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            start     = start_pulse && (i == 0);
            @(negedge clk);
            start = 1'b0;
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(held));
        end
        out_ready = 1'b1;
        start     = start_pulse;
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = 8'($urandom);
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                          input logic [W:0] exp_full, input int stall, input bit rnd,
                          input bit start_pulses, input int abort_at);
        logic [W-1:0] bx;
        logic [W:0]   lowmask;
        logic [W:0]   part;
        bx = s ? ~b : b;
        start = 1'b1;
        sub   = s;
        @(negedge clk);
        start = 1'b0;
        sub   = 1'($urandom);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("in_ready_get_a", 32'(in_ready), 32'd1);
        for (int k = 0; k < N; k++) begin
            feed_byte(a[8*k +: 8], rnd, 1'b0);
            feed_byte(b[8*k +: 8], rnd, start_pulses && (k == 1));
            // Carry entering byte k is bit 8k of the low-k-byte partial sum.
            lowmask = ((W+1)'(1) << (8 * k)) - (W+1)'(1);
            part    = ({1'b0, a} & lowmask) + ({1'b0, bx} & lowmask) + (W+1)'(s);
            chk("add_a", 32'(add_a), 32'(a[8*k +: 8]));
            chk("add_b", 32'(add_b), 32'(bx[8*k +: 8]));
            chk("add_cin", 32'(add_cin), 32'(part[8*k]));
            chk("add_cycle_no_valid", 32'({out_valid, in_ready}), 32'd0);
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            in_data  = 8'($urandom);
            @(negedge clk);
            in_valid = 1'b0;
            if (abort_at == k) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_reset_outputs("midop_reset");
                @(negedge clk);
                chk("post_reset_no_valid", 32'({out_valid, busy}), 32'd0);
                return;
            end
            take_out(exp_full[8*k +: 8], 1'b0, stall, start_pulses && (k == 2));
        end
        take_out({7'b0, exp_full[W]}, 1'b1, stall, 1'b0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_cleared", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb, rbx;
        logic [W:0]   rfull;
        bit           rs;

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 0, 1'b0, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33'h1_0000_0000, 0, 1'b0, 1'b0, -1);
        run_op(32'h0000_0005, 32'h0000_0003, 1'b1, 33'h1_0000_0002, 0, 1'b0, 1'b0, -1);
        run_op(32'h0000_0005, 32'h0000_0006, 1'b1, 33'h0_FFFF_FFFF, 0, 1'b0, 1'b0, -1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 5, 1'b1, 1'b0, -1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 1, 1'b0, 1'b1, -1);
        run_op(32'h0000_0005, 32'h0000_0003, 1'b1, 33'h1_0000_0002, 0, 1'b0, 1'b0, -1);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 33'h0_2345_6789, 0, 1'b0, 1'b0, 2);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 33'h0_0000_0002, 0, 1'b0, 1'b0, -1);

        for (int i = 0; i < 20; i++) begin
            ra    = W'($urandom);
            rb    = (i == 0) ? ra : W'($urandom);
            rs    = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rbx   = rs ? ~rb : rb;
            rfull = {1'b0, ra} + {1'b0, rbx} + (W+1)'(rs);
            run_op(ra, rb, rs, rfull, $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
